// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet TX FCS path.
// The CRC-32 is the reflected form: bits are processed LSB first, and the low nibble goes first.
package eth_pkg;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
   localparam int          ETH_MIN_NIBBLES = 120;
   localparam int          FCS_NIBBLES     = 8;

   typedef enum logic [2:0] {
      S_DATA = 3'b001,
      S_PAD  = 3'b010,
      S_FCS  = 3'b100
   } fcs_state_t;
endpackage

// File: rtl/crc32_4bit.sv
// Combinational update of the reflected Ethernet CRC-32 by one nibble, taken LSB first.
module crc32_4bit
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [3:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 4; i++) begin
         crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/eth_tx_fcs_inserter.sv
// MII TX nibble stream: pass frame data through, zero-pad short frames, then append the FCS.
// Data passes through with zero latency. Pad and FCS nibbles are generated while upstream is stalled.
module eth_tx_fcs_inserter
   import eth_pkg::*;
#(
   parameter bit PAD_EN      = 1'b1,
   parameter int MIN_NIBBLES = ETH_MIN_NIBBLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic [3:0] out_data,
   output logic       out_last,
   input  logic       out_ready
);

   localparam int               CNT_W    = $clog2(MIN_NIBBLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_NIBBLES);
   localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W + 1)'(MIN_NIBBLES);
   localparam logic [2:0]       FCS_LAST = 3'(FCS_NIBBLES - 1);

   fcs_state_t       state, state_nxt;
   logic [31:0]      crc, crc_upd;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_p1;
   logic [2:0]       fcs_idx;
   logic [3:0]       crc_din;
   logic             v_int, r_int, l_int, xfer;
   logic [3:0]       d_int;

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      return (c >= CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   crc32_4bit u_crc (
      .crc_in  (crc),
      .data    (crc_din),
      .crc_out (crc_upd)
   );

   assign cnt_p1 = {1'b0, cnt} + (CNT_W + 1)'(1);

   always_comb begin
      v_int     = 1'b0;
      r_int     = 1'b0;
      l_int     = 1'b0;
      d_int     = 4'h0;
      crc_din   = 4'h0;
      state_nxt = state;
      case (state)
         S_DATA: begin
            v_int   = in_valid;
            r_int   = out_ready;
            d_int   = in_data;
            crc_din = in_data;
            if (in_valid && out_ready && in_last) begin
               state_nxt = (PAD_EN && (cnt_p1 < MIN_EXT)) ? S_PAD : S_FCS;
            end
         end
         S_PAD: begin
            v_int = 1'b1;
            if (out_ready && (cnt_sat_inc(cnt) == CNT_MAX)) state_nxt = S_FCS;
         end
         S_FCS: begin
            v_int = 1'b1;
            d_int = ~crc[{fcs_idx, 2'b00} +: 4];
            l_int = (fcs_idx == FCS_LAST);
            if (out_ready && l_int) state_nxt = S_DATA;
         end
         default: state_nxt = S_DATA;
      endcase
   end

   // Outputs are gated while reset is held so the downstream sees an idle bus.
   assign xfer      = v_int & out_ready;
   assign in_ready  = reset_n & r_int;
   assign out_valid = reset_n & v_int;
   assign out_last  = reset_n & l_int;
   assign out_data  = reset_n ? d_int : 4'h0;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_DATA;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         crc     <= CRC32_INIT;
         cnt     <= '0;
         fcs_idx <= '0;
      end else if (xfer) begin
         case (state)
            S_DATA, S_PAD: begin
               crc <= crc_upd;
               cnt <= cnt_sat_inc(cnt);
            end
            S_FCS: begin
               if (fcs_idx == FCS_LAST) begin
                  crc     <= CRC32_INIT;
                  cnt     <= '0;
                  fcs_idx <= '0;
               end else begin
                  fcs_idx <= fcs_idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Bench for eth_tx_fcs_inserter: random frames against a queue-based frame model,
// plus fixed check-value, padding, reset and back-to-back cases.
module tb_eth_tx_fcs_inserter;
   import eth_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       in_valid, in_last, in_ready, out_valid, out_last, out_ready;
   logic [3:0] in_data, out_data;
   logic       in_valid0, in_last0, in_ready0, out_valid0, out_last0, out_ready0;
   logic [3:0] in_data0, out_data0;

   eth_tx_fcs_inserter #(.PAD_EN(1'b1), .MIN_NIBBLES(120)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
   );

   eth_tx_fcs_inserter #(.PAD_EN(1'b0), .MIN_NIBBLES(120)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid0), .in_data(in_data0), .in_last(in_last0), .in_ready(in_ready0),
      .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0), .out_ready(out_ready0)
   );

   int          errors = 0;
   int          checks = 0;
   logic [4:0]  exp_q[$];
   logic [4:0]  cap0[$];
   logic [3:0]  frm[$];
   logic [3:0]  s9[$];
   logic [3:0]  fcs_ref[8];
   int          beats = 0;
   int          frames_done = 0;
   int          frame_beats = 0;
   int          last_wait = 0;
   int          first_wait = 0;
   logic [31:0] run_crc;
   logic [31:0] last_residue = 32'h0;
   bit          rand_rdy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference CRC: one bit at a time, LSB of each nibble first.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // Frame model: data, zero pad up to 120 nibbles if enabled, then ~crc low nibble first.
   function automatic void model_frame(input bit pad_en);
      logic [3:0]  q[$];
      logic [31:0] c;
      logic [31:0] fcs;
      q = frm;
      while (pad_en && q.size() < 120) q.push_back(4'h0);
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = crc_nib(c, q[i]);
         exp_q.push_back({1'b0, q[i]});
      end
      fcs = ~c;
      for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), fcs[4*k +: 4]});
   endfunction

   task automatic wait_accept();
      int w;
      bit ok;
      w  = 0;
      ok = 1'b0;
      while (!ok && w < 5000) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (!ok) w++;
      end
      last_wait = w;
      if (!ok) chk("in_accept", 32'(ok), 1);
   endtask

   task automatic send_frame(input bit gaps, input bit hold);
      for (int n = 0; n < frm.size(); n++) begin
         if (gaps && n > 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = frm[n];
         in_last  = (n == frm.size() - 1);
         wait_accept();
         if (n == 0) first_wait = last_wait;
      end
      if (!hold) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 5000) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic rand_frame(input int len);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(4'($urandom_range(0, 15)));
   endtask

   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b1;
      in_data    = 4'hA;
      in_last    = 1'b1;
      out_ready  = 1'b1;
      in_valid0  = 1'b1;
      in_data0   = 4'h5;
      in_last0   = 1'b1;
      out_ready0 = 1'b1;
      run_crc    = 32'hFFFF_FFFF;
      fcs_ref    = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

      fork
         begin : mon
            logic [4:0] e;
            forever begin
               @(negedge clk);
               if (reset_n && out_valid && out_ready) begin
                  if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
                  else begin
                     e = exp_q.pop_front();
                     chk("beat", {out_last, out_data}, e);
                  end
                  run_crc = crc_nib(run_crc, out_data);
                  beats++;
                  if (out_last) begin
                     last_residue = run_crc;
                     frame_beats  = beats;
                     beats        = 0;
                     run_crc      = 32'hFFFF_FFFF;
                     frames_done++;
                  end
               end
            end
         end
         begin : mon0
            forever begin
               @(negedge clk);
               if (reset_n && out_valid0 && out_ready0) cap0.push_back({out_last0, out_data0});
            end
         end
         begin : rdy
            forever begin
               @(posedge clk);
               #1;
               out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
         end
      join_none

      // Reset: all outputs gated even with upstream valid and downstream ready.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst0_in_ready", 32'(in_ready0), 0);
      chk("rst0_out_valid", 32'(out_valid0), 0);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = 4'h0;
      in_valid0 = 1'b0;
      in_last0  = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // "123456789" on the unpadded instance: check value 0xCBF43926.
      for (int b = 0; b < 9; b++) begin
         logic [7:0] ch;
         ch = 8'h31 + 8'(b);
         s9.push_back(ch[3:0]);
         s9.push_back(ch[7:4]);
      end
      for (int n = 0; n < 18; n++) begin
         int  w;
         bit  ok;
         in_valid0 = 1'b1;
         in_data0  = s9[n];
         in_last0  = (n == 17);
         w  = 0;
         ok = 1'b0;
         while (!ok && w < 100) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            w++;
         end
         if (!ok) chk("s9_accept", 32'(ok), 1);
      end
      in_valid0 = 1'b0;
      in_last0  = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("s9_beats", cap0.size(), 26);
      for (int i = 0; i < 26; i++) begin
         logic [4:0] ex;
         ex = (i < 18) ? {1'b0, s9[i]} : {(i == 25), fcs_ref[i-18]};
         if (i < cap0.size()) chk("s9_beat", cap0[i], ex);
      end

      // One-byte frame 0xAB: padded to 120 nibbles, residue over the output.
      frm = '{4'hB, 4'hA};
      model_frame(1'b1);
      send_frame(1'b0, 1'b0);
      drain();
      chk("ab_beats", frame_beats, 128);
      chk("ab_residue", last_residue, CRC32_RESIDUE);

      // Exactly the minimum length: no pad beats.
      rand_frame(120);
      model_frame(1'b1);
      send_frame(1'b0, 1'b0);
      drain();
      chk("min_beats", frame_beats, 128);
      chk("min_residue", last_residue, CRC32_RESIDUE);

      // Random frames with random downstream backpressure and upstream gaps.
      begin
         int f0;
         f0 = frames_done;
         rand_rdy = 1'b1;
         for (int f = 0; f < 100; f++) begin
            rand_frame((f % 10 == 0) ? int'($urandom_range(1, 1600)) : int'($urandom_range(1, 160)));
            model_frame(1'b1);
            send_frame(1'b1, 1'b0);
         end
         drain();
         chk("rand_frames", frames_done - f0, 100);
         rand_rdy = 1'b0;
         @(posedge clk);
         #1;
      end

      // Reset pulse during FCS nibble 3, then a clean frame.
      rand_frame(10);
      model_frame(1'b1);
      send_frame(1'b0, 1'b0);
      begin
         int w;
         w = 0;
         while (beats != 123 && w < 1000) begin
            @(posedge clk);
            w++;
         end
         chk("fcs3_reach", beats, 123);
      end
      #1;
      reset_n = 1'b0;
      #1;
      chk("fcs_rst_out_valid", 32'(out_valid), 0);
      chk("fcs_rst_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      beats   = 0;
      run_crc = 32'hFFFF_FFFF;
      rand_frame(30);
      model_frame(1'b1);
      send_frame(1'b0, 1'b0);
      drain();
      chk("post_rst_beats", frame_beats, 128);
      chk("post_rst_residue", last_residue, CRC32_RESIDUE);

      // Back-to-back frames with in_valid held: stall spans exactly pad + FCS.
      rand_frame(10);
      model_frame(1'b1);
      send_frame(1'b0, 1'b1);
      rand_frame(12);
      model_frame(1'b1);
      send_frame(1'b0, 1'b0);
      chk("b2b_stall", first_wait, 118);
      drain();
      chk("b2b_residue", last_residue, CRC32_RESIDUE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
